// File: rtl/hmmm_pkg.sv
// Shared definitions for the Hmmm memory port: default widths and the access FSM encoding.
package hmmm_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/hmmm_mem_interface.sv
// Hmmm CPU memory port: owns MAR/MDR, runs the req/ack handshake to word memory
// and stalls control through busy until each access completes or times out.
module hmmm_mem_interface
    import hmmm_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mdr_load,
    input  logic              mem_write,
    input  logic              mdr_out,
    output logic              busy,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // Timer holds (req cycles so far - 1); the access gives up when it reaches TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    mem_state_t        state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [TMR_W-1:0]  timer;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            timer <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                // DONE accepts new commands exactly like IDLE so accesses can run back-to-back.
                IDLE, DONE: begin
                    timer <= '0;
                    if (mar_in)   mar <= bus[ADDR_W-1:0];
                    if (mdr_load) mdr <= bus;
                    if (mdr_in)         state <= RD;
                    else if (mem_write) state <= WR;
                    else                state <= IDLE;
                end
                RD, WR: begin
                    if (mem_ack) begin
                        if (state == RD) mdr <= mem_rdata;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        fault <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (DATA_W > ADDR_W) begin : g_bus_hi
            logic unused_bus_hi;
            assign unused_bus_hi = ^bus[DATA_W-1:ADDR_W];
        end
    endgenerate

    assign mem_req   = (state == RD) || (state == WR);
    assign mem_we    = (state == WR);
    assign busy      = mem_req;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    // Qualified by rst so the bus is released the moment reset asserts.
    assign bus_oe    = mdr_out & ~busy & rst;
    assign bus_out   = bus_oe ? mdr : '0;

endmodule

// File: tb/tb_hmmm_mem_interface.sv
// Directed bench for hmmm_mem_interface: reset, read, write, conflicts, timeout, back-to-back.
module tb_hmmm_mem_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        mar_in, mdr_in, mdr_load, mem_write, mdr_out;
    logic        busy, fault;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;
    int n;

    hmmm_mem_interface #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_load  (mdr_load),
        .mem_write (mem_write),
        .mdr_out   (mdr_out),
        .busy      (busy),
        .fault     (fault),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; bus = '0; mar_in = 0; mdr_in = 0; mdr_load = 0;
        mem_write = 0; mdr_out = 1'b1; mem_rdata = '0; mem_ack = 0;
        step(); step();
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_fault",   32'(fault),     32'h0);
        check("rst_req",     32'(mem_req),   32'h0);
        check("rst_we",      32'(mem_we),    32'h0);
        check("rst_oe",      32'(bus_oe),    32'h0);
        check("rst_busout",  32'(bus_out),   32'h0);
        check("rst_addr",    32'(mem_addr),  32'h0);
        check("rst_wdata",   32'(mem_wdata), 32'h0);
        rst = 1'b1; mdr_out = 1'b0;
        step();

        // Read 0x2A, ack in third request cycle.
        bus = 16'h002A; mar_in = 1;
        step();
        mar_in = 0; mdr_in = 1;
        check("rd_addr", 32'(mem_addr), 32'h2A);
        step();
        mdr_in = 0;
        check("rd_busy1", 32'(busy),    32'h1);
        check("rd_we",    32'(mem_we),  32'h0);
        step();
        check("rd_busy2", 32'(busy),    32'h1);
        step();
        check("rd_busy3", 32'(busy),    32'h1);
        mem_ack = 1; mem_rdata = 16'hBEEF; mdr_out = 1;
        #1;
        check("rd_oe_busy", 32'(bus_oe), 32'h0);
        step();
        mem_ack = 0;
        check("rd_done_busy", 32'(busy),    32'h0);
        check("rd_done_req",  32'(mem_req), 32'h0);
        check("rd_done_oe",   32'(bus_oe),  32'h1);
        check("rd_done_bus",  32'(bus_out), 32'hBEEF);
        step();
        mdr_out = 0;

        // Stray ack while idle.
        mem_ack = 1; mem_rdata = 16'h5555;
        step();
        mem_ack = 0;
        check("stray_busy",  32'(busy),      32'h0);
        check("stray_mdr",   32'(mem_wdata), 32'hBEEF);

        // Write 0x1234 to 0x10, ack in first request cycle; mar_in while busy ignored.
        bus = 16'h0010; mar_in = 1;
        step();
        bus = 16'h1234; mar_in = 0; mdr_load = 1;
        step();
        mdr_load = 0; mem_write = 1;
        check("wr_pre_wdata", 32'(mem_wdata), 32'h1234);
        step();
        mem_write = 0; mem_ack = 1; mar_in = 1; bus = 16'h00FF;
        check("wr_req",   32'(mem_req),   32'h1);
        check("wr_we",    32'(mem_we),    32'h1);
        check("wr_addr",  32'(mem_addr),  32'h10);
        check("wr_wdata", 32'(mem_wdata), 32'h1234);
        step();
        mem_ack = 0; mar_in = 0;
        check("wr_done_busy", 32'(busy),     32'h0);
        check("wr_mar_frozen", 32'(mem_addr), 32'h10);
        step();

        // mdr_in and mem_write together: read only.
        mdr_in = 1; mem_write = 1;
        step();
        mdr_in = 0; mem_write = 0;
        check("conf_req", 32'(mem_req), 32'h1);
        check("conf_we",  32'(mem_we),  32'h0);
        mem_ack = 1; mem_rdata = 16'h0A0A;
        step();
        mem_ack = 0;
        check("conf_mdr", 32'(mem_wdata), 32'h0A0A);
        step();

        // Timeout with no ack.
        mdr_in = 1; mem_rdata = 16'hDEAD;
        step();
        mdr_in = 0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("to_cycles", 32'(n),         32'd15);
        check("to_fault",  32'(fault),     32'h1);
        check("to_busy",   32'(busy),      32'h0);
        check("to_mdr",    32'(mem_wdata), 32'h0A0A);
        step();

        // Next read still completes; fault stays sticky.
        mdr_in = 1;
        step();
        mdr_in = 0; mem_ack = 1; mem_rdata = 16'h7777;
        step();
        mem_ack = 0;
        check("post_to_mdr",   32'(mem_wdata), 32'h7777);
        check("post_to_fault", 32'(fault),     32'h1);
        check("b2b_gap_req",   32'(mem_req),   32'h0);

        // Write issued in DONE: one idle request cycle between accesses.
        mem_write = 1;
        step();
        mem_write = 0;
        check("b2b_req", 32'(mem_req), 32'h1);
        check("b2b_we",  32'(mem_we),  32'h1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        step();

        // Reset mid-access, late ack after release.
        mdr_in = 1;
        step();
        mdr_in = 0; mdr_out = 1;
        check("mid_req_pre", 32'(mem_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid_req",   32'(mem_req),   32'h0);
        check("mid_busy",  32'(busy),      32'h0);
        check("mid_fault", 32'(fault),     32'h0);
        check("mid_oe",    32'(bus_oe),    32'h0);
        check("mid_bus",   32'(bus_out),   32'h0);
        check("mid_addr",  32'(mem_addr),  32'h0);
        step();
        rst = 1'b1; mdr_out = 0; mem_ack = 1; mem_rdata = 16'h9999;
        step();
        mem_ack = 0;
        check("late_ack_req", 32'(mem_req),   32'h0);
        check("late_ack_mdr", 32'(mem_wdata), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
